decode_stage: RTL and testbench

//   Second pipeline stage, directly downstream of the fetch stage. Holds the IF/ID

---
 rtl/decode_stage_if.sv | 35 +++
 rtl/decode_stage.sv | 76 +++++++
 tb/tb_decode_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, hazard, control and writeback signals of the decode stage
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 10
);
  logic [31:0]     InstrF;
  logic [PC_W-1:0] PCF;
  logic [PC_W-1:0] PCPlus4F;
  logic            StallD;
  logic            FlushD;
  logic [2:0]      ImmSrcD;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic [31:0]     InstrD;
  logic [PC_W-1:0] PCD;
  logic [PC_W-1:0] PCPlus4D;
  logic            ValidD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;

  modport master (
    output InstrF, PCF, PCPlus4F, StallD, FlushD, ImmSrcD, RegWriteW, RdW, ResultW,
    input  InstrD, PCD, PCPlus4D, ValidD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD
  );

  modport slave (
    input  InstrF, PCF, PCPlus4F, StallD, FlushD, ImmSrcD, RegWriteW, RdW, ResultW,
    output InstrD, PCD, PCPlus4D, ValidD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID pipeline register, bypassed register file and immediate generator
module decode_stage #(
  parameter int          XLEN = 32,
  parameter int          PC_W = 10,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input logic            clk,
  input logic            Reset,
  decode_stage_if.slave  bus
);

  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc4_q;
  logic            valid_q;
  logic [XLEN-1:0] regs [32];
  logic            wr_en;

  // Flush wins over stall so a squashed instruction never lingers in ID.
  always_ff @(posedge clk) begin
    if (!Reset || bus.FlushD) begin
      instr_q <= NOP;
      pc_q    <= {PC_W{1'b0}};
      pc4_q   <= {PC_W{1'b0}};
      valid_q <= 1'b0;
    end else if (!bus.StallD) begin
      instr_q <= bus.InstrF;
      pc_q    <= bus.PCF;
      pc4_q   <= bus.PCPlus4F;
      valid_q <= 1'b1;
    end
  end

  assign wr_en = bus.RegWriteW && (bus.RdW != 5'd0);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= {XLEN{1'b0}};
    end else if (wr_en) begin
      regs[bus.RdW] <= bus.ResultW;
    end
  end

  assign bus.InstrD   = instr_q;
  assign bus.PCD      = pc_q;
  assign bus.PCPlus4D = pc4_q;
  assign bus.ValidD   = valid_q;
  assign bus.Rs1D     = instr_q[19:15];
  assign bus.Rs2D     = instr_q[24:20];
  assign bus.RdD      = instr_q[11:7];

  // Write-through: a reader in the same cycle as the writeback sees the new value.
  always_comb begin
    bus.RD1D = {XLEN{1'b0}};
    bus.RD2D = {XLEN{1'b0}};
    if (wr_en && bus.RdW == instr_q[19:15])  bus.RD1D = bus.ResultW;
    else if (instr_q[19:15] != 5'd0)         bus.RD1D = regs[instr_q[19:15]];
    if (wr_en && bus.RdW == instr_q[24:20])  bus.RD2D = bus.ResultW;
    else if (instr_q[24:20] != 5'd0)         bus.RD2D = regs[instr_q[24:20]];
  end

  always_comb begin
    bus.ImmExtD = {XLEN{1'b0}};
    case (bus.ImmSrcD)
      3'b000: bus.ImmExtD = {{20{instr_q[31]}}, instr_q[31:20]};
      3'b001: bus.ImmExtD = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      3'b010: bus.ImmExtD = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                             instr_q[11:8], 1'b0};
      3'b011: bus.ImmExtD = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                             instr_q[30:21], 1'b0};
      3'b100: bus.ImmExtD = {instr_q[31:12], 12'b0};
      default: bus.ImmExtD = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_stage_if #(.XLEN(32), .PC_W(10)) bus ();
  decode_stage dut (.clk(clk), .Reset(Reset), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [31:0] m_instr;
  logic [9:0]  m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_regs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    int v;
    case (sel)
      3'd0: v = int'($signed(ins)) >>> 20;
      3'd1: v = ((int'($signed(ins)) >>> 25) * 32) + int'(ins[11:7]);
      3'd2: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      3'd3: begin
        v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      3'd4: v = int'(ins & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == r) return bus.ResultW;
    return (r == 0) ? 32'd0 : m_regs[r];
  endfunction

  // Advance the model by the rules for one rising edge, then let the DUT take the same edge.
  task automatic step();
    if (!Reset) begin
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (bus.RegWriteW && bus.RdW != 0) m_regs[bus.RdW] = bus.ResultW;
      if (bus.FlushD) begin
        m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
      end else if (!bus.StallD) begin
        m_instr = bus.InstrF; m_pc = bus.PCF; m_pc4 = bus.PCPlus4F; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".InstrD"},   bus.InstrD, m_instr);
    check({tag, ".PCD"},      32'(bus.PCD), 32'(m_pc));
    check({tag, ".PCPlus4D"}, 32'(bus.PCPlus4D), 32'(m_pc4));
    check({tag, ".ValidD"},   32'(bus.ValidD), 32'(m_valid));
    check({tag, ".Rs1D"},     32'(bus.Rs1D), 32'(m_instr[19:15]));
    check({tag, ".Rs2D"},     32'(bus.Rs2D), 32'(m_instr[24:20]));
    check({tag, ".RdD"},      32'(bus.RdD), 32'(m_instr[11:7]));
    check({tag, ".RD1D"},     bus.RD1D, ref_read(m_instr[19:15]));
    check({tag, ".RD2D"},     bus.RD2D, ref_read(m_instr[24:20]));
    check({tag, ".ImmExtD"},  bus.ImmExtD, ref_imm(m_instr, bus.ImmSrcD));
  endtask

  initial begin
    m_instr = 'x; m_pc = 'x; m_pc4 = 'x; m_valid = 'x;
    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    Reset = 1'b0;
    bus.InstrF = 32'hFFF0_0093; bus.PCF = 10'h3F0; bus.PCPlus4F = 10'h3F4;
    bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.ImmSrcD = 3'd0;
    bus.RegWriteW = 1'b1; bus.RdW = 5'd7; bus.ResultW = 32'h5555_AAAA;

    step(); step();
    check("reset.instr_nop", bus.InstrD, 32'h0000_0013);
    check("reset.valid", 32'(bus.ValidD), 32'd0);
    bus.RegWriteW = 1'b0;
    #1 check_all("reset");

    Reset = 1'b1; bus.PCF = 10'h010; bus.PCPlus4F = 10'h014;
    step();
    check("load.instr", bus.InstrD, 32'hFFF0_0093);
    check("load.pc", 32'(bus.PCD), 32'h010);
    check("load.pc4", 32'(bus.PCPlus4D), 32'h014);
    check("load.rd", 32'(bus.RdD), 32'd1);
    check("load.imm", bus.ImmExtD, 32'hFFFF_FFFF);
    check_all("load");

    bus.StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.InstrF = $urandom; bus.PCF = 10'($urandom); bus.PCPlus4F = 10'($urandom);
      step();
      check("stall.hold", bus.InstrD, 32'hFFF0_0093);
      check_all("stall");
    end
    bus.FlushD = 1'b1;
    step();
    check("flush_stall.instr", bus.InstrD, 32'h0000_0013);
    check_all("flush_stall");
    bus.FlushD = 1'b0; bus.StallD = 1'b0;

    // Every register reads back zero after reset.
    for (int r = 1; r < 32; r++) begin
      bus.InstrF = {7'd0, 5'(32 - r), 5'(r), 3'd0, 5'd1, 7'h33};
      step();
      check_all("zero_read");
    end

    bus.InstrF = 32'h0002_8093;
    step();
    bus.StallD = 1'b1; bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'hDEAD_BEEF;
    #1 check("bypass.same_cycle", bus.RD1D, 32'hDEAD_BEEF);
    step();
    bus.RegWriteW = 1'b0;
    #1 check("bypass.after_edge", bus.RD1D, 32'hDEAD_BEEF);
    check_all("bypass");

    bus.StallD = 1'b0; bus.InstrF = 32'h0000_0093;
    step();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = 32'h0000_1234;
    #1 check("x0.before", bus.RD1D, 32'd0);
    step();
    bus.RegWriteW = 1'b0;
    #1 check("x0.after", bus.RD1D, 32'd0);

    bus.InstrF = 32'hFE00_0EE3;
    step();
    bus.ImmSrcD = 3'b010;
    #1 check("imm.b", bus.ImmExtD, 32'hFFFF_FFFC);
    bus.ImmSrcD = 3'b111;
    #1 check("imm.other", bus.ImmExtD, 32'd0);

    for (int n = 0; n < 400; n++) begin
      Reset         = ($urandom_range(0, 39) != 0);
      bus.InstrF    = $urandom;
      bus.PCF       = 10'($urandom);
      bus.PCPlus4F  = 10'($urandom);
      bus.StallD    = ($urandom_range(0, 3) == 0);
      bus.FlushD    = ($urandom_range(0, 7) == 0);
      bus.ImmSrcD   = 3'($urandom_range(0, 7));
      bus.RegWriteW = ($urandom_range(0, 1) == 1);
      bus.RdW       = 5'($urandom);
      bus.ResultW   = $urandom;
      #1 check_all("random");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
